pattern_det_ctrl: RTL

Run controller for a programmable serial bit-pattern detector.
- Software configures the pattern, its length, a match target and a timeout, then issues start.
- The block shifts a qualified serial bit stream through a match core and counts matches.
- It finishes on target reached (DONE) or on timeout (TMO), and raises a sticky interrupt.
- Sits between the register interface and the serial input path; generalises fixed-pattern detectors such as 1011.

---
 rtl/pdc_pkg.sv | 28 ++
 rtl/pdc_match_core.sv | 84 ++++++++
 rtl/pattern_det_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pdc_pkg.sv
// rtl/pdc_pkg.sv - shared types and default widths for the pattern detector
//
// Purpose: run-state encoding, default parameter widths and a configuration
// record used by pattern_det_ctrl and pdc_match_core.
// Ports: none (package).
package pdc_pkg;

   localparam int PDC_PAT_W = 8;
   localparam int PDC_LEN_W = 4;
   localparam int PDC_CNT_W = 16;
   localparam int PDC_TMO_W = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_TMO  = 2'd3
   } pdc_state_t;

   // Configuration record at the default widths.
   typedef struct packed {
      logic [PDC_PAT_W-1:0] pattern;
      logic [PDC_LEN_W-1:0] len;
      logic [PDC_CNT_W-1:0] target;
      logic [PDC_TMO_W-1:0] timeout;
   } pdc_cfg_t;

endpackage

// File: rtl/pdc_match_core.sv
// rtl/pdc_match_core.sv - serial shift register, fill counter and masked pattern compare
//
// Purpose: shifts qualified bits into the LSB of a PAT_W shift register and
// flags a match when at least len bits have arrived and the low len bits
// equal pattern[len-1:0].
// Build option: PDC_OVERLAP_EN defined keeps the fill count after a match so
// overlapping occurrences are counted; undefined restarts the fill count on
// every match.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   clr            clears shift register, fill count and pending match
//   in_valid       qualifies in_bit (shift only when high)
//   in_bit         serial data bit
//   pattern, len   pattern and its length (len assumed legal)
//   hit            combinational: this beat completes a match
//   match          registered hit, one-cycle pulse
module pdc_match_core
   import pdc_pkg::*;
#(
   parameter int PAT_W = PDC_PAT_W,
   parameter int LEN_W = PDC_LEN_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   output logic             hit,
   output logic             match
);

   logic [PAT_W-1:0] r_sr;
   logic [LEN_W-1:0] r_fill;
   logic             r_match;

   logic [PAT_W-1:0] w_sr_nxt;
   logic [PAT_W-1:0] w_mask;
   logic [LEN_W-1:0] w_fill_nxt;
   logic             w_hit;

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         w_mask[i] = (LEN_W'(i) < len);
      end
   end

   assign w_sr_nxt   = {r_sr[PAT_W-2:0], in_bit};
   assign w_fill_nxt = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);

   // Compare against the post-shift view so the completing beat itself counts.
   assign w_hit = in_valid && (w_fill_nxt >= len) &&
                  ((w_sr_nxt & w_mask) == (pattern & w_mask));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sr    <= '0;
         r_fill  <= '0;
         r_match <= 1'b0;
      end else if (clr) begin
         r_sr    <= '0;
         r_fill  <= '0;
         r_match <= 1'b0;
      end else begin
         r_match <= w_hit;
         if (in_valid) begin
            r_sr <= w_sr_nxt;
`ifdef PDC_OVERLAP_EN
            r_fill <= w_fill_nxt;
`else
            // Stale bits left in r_sr are harmless: len fresh bits must
            // arrive before the fill count allows another compare.
            r_fill <= w_hit ? '0 : w_fill_nxt;
`endif
         end
      end
   end

   assign hit   = w_hit;
   assign match = r_match;

endmodule

// File: rtl/pattern_det_ctrl.sv
// rtl/pattern_det_ctrl.sv - run controller for a programmable serial pattern detector
//
// Purpose: holds configuration, runs IDLE/RUN/DONE/TMO, counts matches from
// pdc_match_core, tracks the run timeout and raises a sticky interrupt.
// Build option: PDC_OVERLAP_EN (overlapping matches, see pdc_match_core).
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   cfg_we, cfg_*              configuration load (ignored in RUN)
//   start, abort               single-cycle run control
//   in_valid, in_bit           qualified serial input
//   busy, done, timeout        state levels (RUN, DONE, TMO)
//   match, match_cnt           match pulse and run match count
//   irq, irq_clr               sticky interrupt and its clear
module pattern_det_ctrl
   import pdc_pkg::*;
#(
   parameter int PAT_W = PDC_PAT_W,
   parameter int LEN_W = PDC_LEN_W,
   parameter int CNT_W = PDC_CNT_W,
   parameter int TMO_W = PDC_TMO_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic [TMO_W-1:0] cfg_timeout,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             busy,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             done,
   output logic             timeout,
   output logic             irq,
   input  logic             irq_clr
);

   pdc_state_t       r_state;
   pdc_state_t       w_state_nxt;

   logic [PAT_W-1:0] r_cfg_pattern;
   logic [LEN_W-1:0] r_cfg_len;
   logic [CNT_W-1:0] r_cfg_target;
   logic [TMO_W-1:0] r_cfg_timeout;

   logic [PAT_W-1:0] r_shd_pattern;
   logic [LEN_W-1:0] r_shd_len;
   logic [CNT_W-1:0] r_shd_target;
   logic [TMO_W-1:0] r_shd_timeout;

   logic [CNT_W-1:0] r_cnt;
   logic [TMO_W-1:0] r_timer;
   logic             r_irq;

   logic             w_len_ok;
   logic             w_enter_run;
   logic             w_set_irq;
   logic             w_core_clr;
   logic             w_core_valid;
   logic             w_hit;
   logic             w_core_match;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_tgt_hit;
   logic             w_tmo_hit;

   assign w_len_ok     = (r_cfg_len != '0) && (r_cfg_len <= LEN_W'(PAT_W));
   assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_tgt_hit    = w_hit && (r_shd_target != '0) && (w_cnt_inc == r_shd_target);
   assign w_tmo_hit    = (r_shd_timeout != '0) && (r_timer == r_shd_timeout - TMO_W'(1));
   assign w_core_valid = in_valid && (r_state == S_RUN);
   // Abort also clears the core so a match pulse due next cycle never appears.
   assign w_core_clr   = abort || w_enter_run;

   always_comb begin
      w_state_nxt = r_state;
      w_enter_run = 1'b0;
      w_set_irq   = 1'b0;
      if (abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_tgt_hit) begin
                  w_state_nxt = S_DONE;
                  w_set_irq   = 1'b1;
               end else if (w_tmo_hit) begin
                  w_state_nxt = S_TMO;
                  w_set_irq   = 1'b1;
               end
            end
            default: begin
               if (start && w_len_ok) begin
                  w_state_nxt = S_RUN;
                  w_enter_run = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cfg_pattern <= '0;
         r_cfg_len     <= '0;
         r_cfg_target  <= '0;
         r_cfg_timeout <= '0;
         r_shd_pattern <= '0;
         r_shd_len     <= '0;
         r_shd_target  <= '0;
         r_shd_timeout <= '0;
      end else begin
         if (cfg_we && (r_state != S_RUN)) begin
            r_cfg_pattern <= cfg_pattern;
            r_cfg_len     <= cfg_len;
            r_cfg_target  <= cfg_target;
            r_cfg_timeout <= cfg_timeout;
         end
         if (w_enter_run) begin
            r_shd_pattern <= r_cfg_pattern;
            r_shd_len     <= r_cfg_len;
            r_shd_target  <= r_cfg_target;
            r_shd_timeout <= r_cfg_timeout;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt   <= '0;
         r_timer <= '0;
         r_irq   <= 1'b0;
      end else begin
         if (w_enter_run) begin
            r_cnt <= '0;
         end else if (!abort && (r_state == S_RUN) && w_hit) begin
            r_cnt <= w_cnt_inc;
         end

         if (w_enter_run) begin
            r_timer <= '0;
         end else if (r_state == S_RUN) begin
            r_timer <= r_timer + TMO_W'(1);
         end

         if (w_set_irq) begin
            r_irq <= 1'b1;
         end else if (irq_clr) begin
            r_irq <= 1'b0;
         end
      end
   end

   pdc_match_core #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_core (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (w_core_clr),
      .in_valid (w_core_valid),
      .in_bit   (in_bit),
      .pattern  (r_shd_pattern),
      .len      (r_shd_len),
      .hit      (w_hit),
      .match    (w_core_match)
   );

   assign busy      = (r_state == S_RUN);
   assign done      = (r_state == S_DONE);
   assign timeout   = (r_state == S_TMO);
   assign match     = w_core_match;
   assign match_cnt = r_cnt;
   assign irq       = r_irq;

endmodule
